// File: rtl/systolic_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_feeder_if
//   Interface bundling the feeder's job control, input beat handshake and the
//   skewed output buses toward the systolic array.
//   master : upstream producer side (drives start, in_valid, a_col, b_row)
//   slave  : the feeder itself (drives in_ready, matrix_vals, weight_matrix,
//            load, busy, done)
//   Lane i of every N*DW bus lives at bits [i*DW +: DW].
// -----------------------------------------------------------------------------
interface systolic_feeder_if #(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 4
);
    localparam int BUS_W = ARRAY_SIZE * DATA_WIDTH;

    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] a_col;
    logic [BUS_W-1:0] b_row;
    logic [BUS_W-1:0] matrix_vals;
    logic [BUS_W-1:0] weight_matrix;
    logic             load;
    logic             busy;
    logic             done;

    modport master (
        output start, in_valid, a_col, b_row,
        input  in_ready, matrix_vals, weight_matrix, load, busy, done
    );

    modport slave (
        input  start, in_valid, a_col, b_row,
        output in_ready, matrix_vals, weight_matrix, load, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//   Upstream stage of an N x N systolic array. Accepts N K-slices (column k of
//   A, row k of B) over a valid/ready handshake and emits them as a diagonally
//   skewed wavefront: lane i lags lane 0 by i cycles. After the last beat the
//   buses are zero-padded for DRAIN_CYCLES so the final partial sums reach the
//   bottom row, then done pulses for one cycle.
// Ports
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high; returns to IDLE and zeroes all stages
//   bus    : systolic_feeder_if.slave
//            start/in_valid/a_col/b_row in; in_ready/matrix_vals/
//            weight_matrix/load/busy/done out
// -----------------------------------------------------------------------------
module systolic_feeder #(
    parameter int ARRAY_SIZE   = 4,
    parameter int DATA_WIDTH   = 4,
    parameter int DRAIN_CYCLES = 3 * ARRAY_SIZE - 2
) (
    input  logic              clk,
    input  logic              reset,
    systolic_feeder_if.slave  bus
);
    localparam int N       = ARRAY_SIZE;
    localparam int DW      = DATA_WIDTH;
    localparam int BEAT_W  = $clog2(N + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e               state_q,     state_d;
    logic [BEAT_W-1:0]    beat_cnt_q,  beat_cnt_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 load_q,      load_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic                 accept;

    // ---------------------------------------------------------------- control
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        accept      = (state_q == S_FILL) && bus.in_valid;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_FILL;
                    beat_cnt_d = '0;
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (beat_cnt_q == BEAT_W'(N - 1)) begin
                        state_d     = S_DRAIN;
                        beat_cnt_d  = '0;
                        drain_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d     = S_DONE;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state and registered, so they
        // line up exactly with state_q without a glitchy decode on the port.
        load_d = (state_d == S_FILL) || (state_d == S_DRAIN);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready = (state_q == S_FILL);
    assign bus.load     = load_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // ---------------------------------------------------------- skew pipeline
    // Lane i is an (i+1)-deep shift register with no enable. Non-accept
    // cycles inject zeros, so bubbles and the drain phase shift uniformly and
    // keep A and B aligned across lanes.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a_stage_q [0:i];
        logic [DW-1:0] a_stage_d [0:i];
        logic [DW-1:0] b_stage_q [0:i];
        logic [DW-1:0] b_stage_d [0:i];

        always_comb begin
            a_stage_d[0] = accept ? bus.a_col[i*DW +: DW] : '0;
            b_stage_d[0] = accept ? bus.b_row[i*DW +: DW] : '0;
            for (int s = 1; s <= i; s++) begin
                a_stage_d[s] = a_stage_q[s-1];
                b_stage_d[s] = b_stage_q[s-1];
            end
        end

        // NOTE: the skew stages are reset too: a reset mid-job must not let
        // stale beats of the aborted job leak onto the array buses.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) begin
                    a_stage_q[s] <= '0;
                    b_stage_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s <= i; s++) begin
                    a_stage_q[s] <= a_stage_d[s];
                    b_stage_q[s] <= b_stage_d[s];
                end
            end
        end

        assign bus.matrix_vals[i*DW +: DW]   = a_stage_q[i];
        assign bus.weight_matrix[i*DW +: DW] = b_stage_q[i];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//   Self-checking bench. The reference model works on job timestamps: the
//   cycle start was honoured, how many beats were taken, the cycle of the last
//   beat, and a per-cycle history of the accepted slices. Expected bus lane i
//   in cycle c is simply the slice accepted in cycle c-1-i (zero if none).
//   Inputs are driven and outputs checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;
    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int DRAIN = 3 * N - 2;
    localparam int W     = N * DW;
    localparam int MAXC  = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    systolic_feeder_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW)) fif ();

    systolic_feeder #(
        .ARRAY_SIZE  (N),
        .DATA_WIDTH  (DW),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (fif.slave)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ bookkeeping
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state
    logic [W-1:0] hist_a [0:MAXC-1];
    logic [W-1:0] hist_b [0:MAXC-1];
    int job_start = -1;
    int n_acc     = 0;
    int last_acc  = -1;
    int epoch     = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    function automatic bit exp_busy();
        bit started = (job_start >= 0) && (cyc > job_start);
        bit ended   = (last_acc >= 0) && (cyc > last_acc + DRAIN + 1);
        return started && !ended;
    endfunction

    function automatic bit exp_fill();
        return (job_start >= 0) && (cyc > job_start) && (last_acc < 0);
    endfunction

    function automatic bit exp_done();
        return (last_acc >= 0) && (cyc == last_acc + DRAIN + 1);
    endfunction

    function automatic bit exp_idle();
        return !exp_busy();
    endfunction

    function automatic logic [W-1:0] exp_bus(input bit is_a);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = cyc - 1 - i;
            if (idx >= 0 && idx >= epoch)
                r[i*DW +: DW] = is_a ? hist_a[idx][i*DW +: DW] : hist_b[idx][i*DW +: DW];
        end
        return r;
    endfunction

    task automatic check_outputs();
        check("in_ready",      W'(fif.in_ready),  W'(exp_fill()));
        check("load",          W'(fif.load),      W'(exp_busy() && !exp_done()));
        check("busy",          W'(fif.busy),      W'(exp_busy()));
        check("done",          W'(fif.done),      W'(exp_done()));
        check("matrix_vals",   fif.matrix_vals,   exp_bus(1'b1));
        check("weight_matrix", fif.weight_matrix, exp_bus(1'b0));
    endtask

    // One cycle: check this cycle's outputs, drive inputs, advance the model.
    task automatic run_cycle(input logic st, input logic iv,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        check_outputs();
        fif.start    = st;
        fif.in_valid = iv;
        fif.a_col    = a;
        fif.b_row    = b;
        acc = iv && exp_fill();
        if (cyc < MAXC) begin
            hist_a[cyc] = acc ? a : '0;
            hist_b[cyc] = acc ? b : '0;
        end
        if (acc) begin
            n_acc++;
            if (n_acc == N) last_acc = cyc;
        end
        if (st && exp_idle()) begin
            job_start = cyc;
            n_acc     = 0;
            last_acc  = -1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle: outputs must clear without waiting for an edge.
    task automatic do_reset();
        check_outputs();
        fif.start    = 1'b0;
        fif.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        check("rst_in_ready", W'(fif.in_ready), '0);
        check("rst_load",     W'(fif.load),     '0);
        check("rst_busy",     W'(fif.busy),     '0);
        check("rst_done",     W'(fif.done),     '0);
        check("rst_mvals",    fif.matrix_vals,  '0);
        check("rst_weights",  fif.weight_matrix,'0);
        job_start = -1;
        n_acc     = 0;
        last_acc  = -1;
        epoch     = cyc + 1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
    endtask

    // mode 0: ramp beats k+1, mode 1: bubble in 2nd fill cycle,
    // mode 2: signed -8 / 7 pass-through, mode 3: random
    task automatic run_job(input int mode);
        int k;
        int f;
        int budget;
        logic iv;
        logic st;
        logic [W-1:0] a;
        logic [W-1:0] b;
        k = 0;
        f = 0;
        budget = 0;
        run_cycle(1'b1, (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0,
                  W'($urandom), W'($urandom));
        while (last_acc < 0 && budget < 200) begin
            case (mode)
                0: begin iv = 1'b1;     a = {N{DW'(k + 1)}}; b = a; end
                1: begin iv = (f != 1); a = {N{DW'(k + 1)}}; b = a; end
                2: begin iv = 1'b1;     a = {N{DW'(8)}};     b = {N{DW'(7)}}; end
                default: begin
                    iv = ($urandom_range(0, 3) != 0);
                    a  = W'($urandom);
                    b  = W'($urandom);
                end
            endcase
            st = (mode == 3) && ($urandom_range(0, 7) == 0);
            begin
                int prev;
                prev = n_acc;
                run_cycle(st, iv, a, b);
                if (n_acc > prev) k++;
            end
            f++;
            budget++;
        end
        if (budget >= 200) check("fill_timeout", W'(1), W'(0));
        budget = 0;
        while (!exp_idle() && budget < 100) begin
            st = (mode == 3) && ($urandom_range(0, 3) == 0);
            iv = (mode == 3) && ($urandom_range(0, 1) == 0);
            run_cycle(st, iv, W'($urandom), W'($urandom));
            budget++;
        end
        if (budget >= 100) check("drain_timeout", W'(1), W'(0));
        run_cycle(1'b0, 1'b0, '0, '0);
    endtask

    // --------------------------------------------------------------- sequence
    initial begin
        for (int c = 0; c < MAXC; c++) begin
            hist_a[c] = '0;
            hist_b[c] = '0;
        end
        fif.start    = 1'b0;
        fif.in_valid = 1'b0;
        fif.a_col    = '0;
        fif.b_row    = '0;
        @(negedge clk);
        check("init_in_ready", W'(fif.in_ready), '0);
        check("init_load",     W'(fif.load),     '0);
        check("init_busy",     W'(fif.busy),     '0);
        check("init_done",     W'(fif.done),     '0);
        check("init_mvals",    fif.matrix_vals,  '0);
        check("init_weights",  fif.weight_matrix,'0);
        reset = 1'b0;
        cyc   = 1;
        epoch = 1;

        run_cycle(1'b0, 1'b1, W'(16'h1234), W'(16'h5678));  // idle: nothing taken
        run_job(0);
        run_job(1);
        run_job(2);

        // reset while draining (4th drain cycle), then a clean job
        run_cycle(1'b1, 1'b0, '0, '0);
        for (int k = 0; k < N; k++)
            run_cycle(1'b0, 1'b1, {N{DW'(k + 9)}}, {N{DW'(k + 3)}});
        for (int d = 0; d < 3; d++)
            run_cycle(1'b0, 1'b0, '0, '0);
        do_reset();
        run_job(0);

        for (int j = 0; j < 20; j++) begin
            run_job(3);
            for (int g = $urandom_range(0, 3); g > 0; g--)
                run_cycle(1'b0, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end

        // reset in the middle of FILL
        run_cycle(1'b1, 1'b0, '0, '0);
        run_cycle(1'b0, 1'b1, W'($urandom), W'($urandom));
        run_cycle(1'b0, 1'b1, W'($urandom), W'($urandom));
        do_reset();
        run_job(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
